// File: rtl/dsp_seq_ctrl.sv
// Request sequencer for a multi-beat DSP slice: issues registered drive beats per op
// and collects the final accumulate result into a 2-entry response FIFO.
module dsp_seq_ctrl #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned SHIFT_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WIDTH-1:0]      req_a,
    input  logic [WIDTH-1:0]      req_b,
    input  logic [2*WIDTH-1:0]    req_c,
    input  logic [1:0]            req_mode,
    input  logic                  req_mac,
    input  logic [SHIFT_BITS-1:0] req_shift_amount,
    input  logic                  req_shift_dir,
    output logic                  dsp_start,
    output logic [1:0]            dsp_mode,
    output logic [WIDTH-1:0]      dsp_aa,
    output logic [WIDTH-1:0]      dsp_bb,
    output logic [2*WIDTH-1:0]    dsp_cc,
    output logic                  dsp_mac,
    output logic [SHIFT_BITS-1:0] dsp_shift_amount,
    output logic                  dsp_shift_dir,
    input  logic [2*WIDTH-1:0]    dsp_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state, state_nxt;
    logic [1:0] beat, beat_nxt;
    logic [1:0] beat_last, beat_last_nxt;
    logic       err_op, err_op_nxt;
    logic       rst_done;

    logic                  start_nxt, mac_nxt, dir_nxt;
    logic [1:0]            mode_nxt;
    logic [WIDTH-1:0]      aa_nxt, bb_nxt;
    logic [2*WIDTH-1:0]    cc_nxt;
    logic [SHIFT_BITS-1:0] amt_nxt;

    logic [2*WIDTH-1:0] fifo_data [2];
    logic               fifo_err  [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;

    logic       last_beat, push, pop, accept;
    logic [2:0] count_after;

    assign last_beat   = (state == ISSUE) && (beat == beat_last);
    assign push        = last_beat;
    assign rsp_valid   = (count != 2'd0);
    assign pop         = rsp_valid && rsp_ready;
    assign count_after = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    // rst_done keeps req_ready low while in reset even though state reads IDLE
    assign req_ready   = rst_done && ((state == IDLE) || last_beat) && (count_after <= 3'd1);
    assign accept      = req_valid && req_ready;
    assign busy        = (state == ISSUE) || rsp_valid;
    assign rsp_data    = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err     = rsp_valid ? fifo_err[rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            beat             <= '0;
            beat_last        <= '0;
            err_op           <= 1'b0;
            rst_done         <= 1'b0;
            dsp_start        <= 1'b0;
            dsp_mode         <= 2'd3;
            dsp_aa           <= '0;
            dsp_bb           <= '0;
            dsp_cc           <= '0;
            dsp_mac          <= 1'b0;
            dsp_shift_amount <= '0;
            dsp_shift_dir    <= 1'b0;
        end else begin
            state            <= state_nxt;
            beat             <= beat_nxt;
            beat_last        <= beat_last_nxt;
            err_op           <= err_op_nxt;
            rst_done         <= 1'b1;
            dsp_start        <= start_nxt;
            dsp_mode         <= mode_nxt;
            dsp_aa           <= aa_nxt;
            dsp_bb           <= bb_nxt;
            dsp_cc           <= cc_nxt;
            dsp_mac          <= mac_nxt;
            dsp_shift_amount <= amt_nxt;
            dsp_shift_dir    <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        beat_last_nxt = beat_last;
        err_op_nxt    = err_op;
        start_nxt     = 1'b0;
        mode_nxt      = 2'd3;
        aa_nxt        = '0;
        bb_nxt        = '0;
        cc_nxt        = '0;
        mac_nxt       = 1'b0;
        amt_nxt       = '0;
        dir_nxt       = 1'b0;
        if (accept) begin
            state_nxt  = ISSUE;
            beat_nxt   = '0;
            err_op_nxt = (req_mode == 2'd3);
            case (req_mode)
                2'd1:    beat_last_nxt = 2'd1;
                2'd2:    beat_last_nxt = 2'd3;
                default: beat_last_nxt = 2'd0;
            endcase
            // mode 3 is an error op: it keeps the idle drive state for its beat
            if (req_mode != 2'd3) begin
                start_nxt = 1'b1;
                mode_nxt  = req_mode;
                aa_nxt    = req_a;
                bb_nxt    = req_b;
                cc_nxt    = req_c;
                mac_nxt   = req_mac;
                amt_nxt   = req_shift_amount;
                dir_nxt   = req_shift_dir;
            end
        end else if (state == ISSUE && !last_beat) begin
            beat_nxt = beat + 2'd1;
            mode_nxt = dsp_mode;
            aa_nxt   = dsp_aa;
            bb_nxt   = dsp_bb;
            cc_nxt   = dsp_cc;
            mac_nxt  = dsp_mac;
            amt_nxt  = dsp_shift_amount;
            dir_nxt  = dsp_shift_dir;
        end else if (last_beat) begin
            state_nxt  = IDLE;
            beat_nxt   = '0;
            err_op_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= err_op ? '0 : dsp_out;
            fifo_err[wr_ptr]  <= err_op;
        end
    end

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Directed bench for dsp_seq_ctrl with a behavioural multiply-accumulate DSP attached.
module tb_dsp_seq_ctrl;

    localparam int unsigned W  = 33;
    localparam int unsigned SB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_a = '0, req_b = '0;
    logic [2*W-1:0] req_c = '0;
    logic [1:0]    req_mode = 2'd0;
    logic          req_mac = 1'b0;
    logic [SB-1:0] req_shift_amount = '0;
    logic          req_shift_dir = 1'b0;
    logic          dsp_start, dsp_mac, dsp_shift_dir;
    logic [1:0]    dsp_mode;
    logic [W-1:0]  dsp_aa, dsp_bb;
    logic [2*W-1:0] dsp_cc, dsp_out;
    logic [SB-1:0] dsp_shift_amount;
    logic          rsp_valid, rsp_err, busy;
    logic          rsp_ready = 1'b1;
    logic [2*W-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsp_seq_ctrl #(.WIDTH(W), .SHIFT_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mode(req_mode),
        .req_mac(req_mac), .req_shift_amount(req_shift_amount), .req_shift_dir(req_shift_dir),
        .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
        .dsp_cc(dsp_cc), .dsp_mac(dsp_mac), .dsp_shift_amount(dsp_shift_amount),
        .dsp_shift_dir(dsp_shift_dir), .dsp_out(dsp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    // DSP model: aa*bb plus either cc or the shifted previous result when chaining
    logic           last_mac = 1'b0;
    logic           chain_hold = 1'b0;
    logic           chain_now;
    logic [2*W-1:0] prev_res = '0;
    logic [2*W-1:0] prod, shifted;
    assign prod      = {{W{1'b0}}, dsp_aa} * {{W{1'b0}}, dsp_bb};
    assign shifted   = dsp_shift_dir ? (prev_res >> dsp_shift_amount) : (prev_res << dsp_shift_amount);
    assign chain_now = dsp_start ? (dsp_mac && last_mac) : chain_hold;
    assign dsp_out   = prod + (chain_now ? shifted : dsp_cc);
    always @(posedge clk) begin
        last_mac <= dsp_mac;
        prev_res <= dsp_out;
        if (dsp_start) chain_hold <= chain_now;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] c, input logic mac);
        req_valid = v; req_mode = m; req_a = a; req_b = b; req_c = c; req_mac = mac;
        req_shift_amount = '0; req_shift_dir = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        tick(); tick();
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_tests++; if (dsp_mode !== 2'd3 || dsp_start !== 1'b0 || dsp_aa !== '0 || dsp_mac !== 1'b0)
            begin n_fail++; $display("FAIL rst_dsp: got mode=%0d start=%b aa=%0h mac=%b exp 3/0/0/0", dsp_mode, dsp_start, dsp_aa, dsp_mac); end
        n_tests++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %0h/%b exp 0/0", rsp_data, rsp_err); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_pre_edge: got %b exp 0", req_ready); end
        tick();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_post_edge: got %b exp 1", req_ready); end
    endtask

    task automatic test_mode0;
        drive(1, 2'd0, 3, 5, 7, 0);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL m0_ready: got %b exp 1", req_ready); end
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        n_tests++; if (dsp_start !== 1'b1 || dsp_mode !== 2'd0 || dsp_aa !== 33'd3 || dsp_bb !== 33'd5 || dsp_cc !== 66'd7)
            begin n_fail++; $display("FAIL m0_beat: got start=%b mode=%0d aa=%0d bb=%0d cc=%0d exp 1/0/3/5/7", dsp_start, dsp_mode, dsp_aa, dsp_bb, dsp_cc); end
        n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL m0_t1: got rsp_valid=%b busy=%b exp 0/1", rsp_valid, busy); end
        tick();
        n_tests++; if (dsp_start !== 1'b0 || dsp_mode !== 2'd3) begin n_fail++; $display("FAIL m0_idle: got start=%b mode=%0d exp 0/3", dsp_start, dsp_mode); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd22 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL m0_rsp: got v=%b data=%0d err=%b exp 1/22/0", rsp_valid, rsp_data, rsp_err); end
        tick();
        n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL m0_pop: got v=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_mode2;
        drive(1, 2'd2, 33'h0_0001_0002, 33'h0_0003_0004, 0, 0);
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (req_ready !== (i == 4) || dsp_start !== (i == 1) || dsp_mode !== 2'd2 || dsp_aa !== 33'h0_0001_0002)
                begin n_fail++; $display("FAIL m2_beat%0d: got ready=%b start=%b mode=%0d aa=%0h", i, req_ready, dsp_start, dsp_mode, dsp_aa); end
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL m2_early_rsp%0d: got %b exp 0", i, rsp_valid); end
            tick();
        end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'h3_000A_0008 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL m2_rsp: got v=%b data=%0h err=%b exp 1/3000a0008/0", rsp_valid, rsp_data, rsp_err); end
        tick();
    endtask

    task automatic test_mac_chain;
        drive(1, 2'd0, 2, 3, 10, 1);
        tick();
        drive(1, 2'd0, 4, 5, 99, 1);
        n_tests++; if (req_ready !== 1'b1 || dsp_start !== 1'b1 || dsp_mac !== 1'b1)
            begin n_fail++; $display("FAIL mac_b2b_ready: got ready=%b start=%b mac=%b exp 1/1/1", req_ready, dsp_start, dsp_mac); end
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        n_tests++; if (dsp_start !== 1'b1 || dsp_mac !== 1'b1 || dsp_aa !== 33'd4)
            begin n_fail++; $display("FAIL mac_second_beat: got start=%b mac=%b aa=%0d exp 1/1/4", dsp_start, dsp_mac, dsp_aa); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd16) begin n_fail++; $display("FAIL mac_rsp1: got v=%b data=%0d exp 1/16", rsp_valid, rsp_data); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd36) begin n_fail++; $display("FAIL mac_rsp2: got v=%b data=%0d exp 1/36", rsp_valid, rsp_data); end
        n_tests++; if (dsp_mac !== 1'b0) begin n_fail++; $display("FAIL mac_idle: got %b exp 0", dsp_mac); end
        drive(1, 2'd0, 2, 3, 10, 1);
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd16) begin n_fail++; $display("FAIL mac_gap_rsp1: got v=%b data=%0d exp 1/16", rsp_valid, rsp_data); end
        drive(1, 2'd0, 4, 5, 99, 1);
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd119) begin n_fail++; $display("FAIL mac_gap_rsp2: got v=%b data=%0d exp 1/119", rsp_valid, rsp_data); end
        tick();
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        drive(1, 2'd0, 1, 1, 0, 0);
        tick();
        drive(1, 2'd0, 2, 2, 0, 0);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_ready: got %b exp 1", req_ready); end
        tick();
        drive(1, 2'd0, 3, 3, 1, 0);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_ready: got %b exp 0", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (req_ready !== 1'b0 || dsp_start !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got ready=%b start=%b exp 0/0", i, req_ready, dsp_start); end
            n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd1) begin n_fail++; $display("FAIL bp_head%0d: got v=%b data=%0d exp 1/1", i, rsp_valid, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_pop: got %b exp 1", req_ready); end
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        n_tests++; if (dsp_start !== 1'b1 || dsp_aa !== 33'd3) begin n_fail++; $display("FAIL bp_third_issue: got start=%b aa=%0d exp 1/3", dsp_start, dsp_aa); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd4) begin n_fail++; $display("FAIL bp_order2: got v=%b data=%0d exp 1/4", rsp_valid, rsp_data); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd10) begin n_fail++; $display("FAIL bp_order3: got v=%b data=%0d exp 1/10", rsp_valid, rsp_data); end
        tick();
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_mode3;
        drive(1, 2'd3, 5, 5, 5, 1);
        tick();
        drive(1, 2'd0, 6, 7, 1, 0);
        n_tests++; if (dsp_start !== 1'b0 || dsp_mode !== 2'd3 || dsp_aa !== '0 || dsp_mac !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL m3_beat: got start=%b mode=%0d aa=%0d mac=%b busy=%b exp 0/3/0/0/1", dsp_start, dsp_mode, dsp_aa, dsp_mac, busy); end
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_err !== 1'b1)
            begin n_fail++; $display("FAIL m3_rsp: got v=%b data=%0d err=%b exp 1/0/1", rsp_valid, rsp_data, rsp_err); end
        n_tests++; if (dsp_start !== 1'b1 || dsp_aa !== 33'd6) begin n_fail++; $display("FAIL m3_next_issue: got start=%b aa=%0d exp 1/6", dsp_start, dsp_aa); end
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd43 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL m3_next_rsp: got v=%b data=%0d err=%b exp 1/43/0", rsp_valid, rsp_data, rsp_err); end
        tick();
    endtask

    task automatic test_reset_mid_op;
        drive(1, 2'd2, 9, 9, 0, 0);
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if (dsp_start !== 1'b0 || dsp_mode !== 2'd3 || dsp_aa !== '0 || dsp_bb !== '0 || busy !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL rmid_async: got start=%b mode=%0d aa=%0d bb=%0d busy=%b ready=%b v=%b", dsp_start, dsp_mode, dsp_aa, dsp_bb, busy, req_ready, rsp_valid); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_no_rsp%0d: got v=%b ready=%b exp 0/1", i, rsp_valid, req_ready); end
            tick();
        end
        drive(1, 2'd0, 1, 1, 0, 1);
        tick();
        drive(0, 2'd0, 0, 0, 0, 0);
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 66'd1 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL rmid_new_op: got v=%b data=%0d err=%b exp 1/1/0", rsp_valid, rsp_data, rsp_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode2();
        test_mac_chain();
        test_backpressure();
        test_mode3();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
